grid_editor: RTL and testbench

Mouse-driven writer for the 12x12 ship grid memory. Converts a left-button click at the current mouse position into a read-modify-write of the addressed grid cell, toggling it between empty and ship, and provides a full-grid clear sequence. Sits between the mouse interface and the write port of the grid RAM whose read port feeds the ship-drawing VGA stage. Cell addressing matches that stage: addr = {col[3:0], row[3:0]}.

---
 rtl/grid_editor_if.sv | 40 ++++
 rtl/grid_editor.sv | 163 ++++++++++++++++
 tb/tb_grid_editor.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_editor_if.sv
// Bus bundle between the mouse/clear sources, the grid RAM write/read ports
// and the grid editor; master is the editor side, slave is the environment.
interface grid_editor_if;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        clear;
    logic [1:0]  grid_rd_data;
    logic [7:0]  grid_addr;
    logic [1:0]  grid_wr_data;
    logic        grid_we;
    logic        busy;
    logic [7:0]  ship_count;

    modport master (
        input  mouse_xpos,
        input  mouse_ypos,
        input  mouse_left,
        input  clear,
        input  grid_rd_data,
        output grid_addr,
        output grid_wr_data,
        output grid_we,
        output busy,
        output ship_count
    );

    modport slave (
        output mouse_xpos,
        output mouse_ypos,
        output mouse_left,
        output clear,
        output grid_rd_data,
        input  grid_addr,
        input  grid_wr_data,
        input  grid_we,
        input  busy,
        input  ship_count
    );
endinterface

// File: rtl/grid_editor.sv
// Mouse-driven editor for the 12x12 ship grid: a click toggles the addressed
// cell EMPTY<->SHIP via read-modify-write; clear wipes all 144 cells.
module grid_editor #(
    parameter int X_POS     = 0,
    parameter int Y_POS     = 0,
    parameter int MAX_SHIPS = 20
) (
    input  logic          clk,
    input  logic          rst,
    grid_editor_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CHK  = 3'd2,
        WR   = 3'd3,
        CLR  = 3'd4
    } state_t;

    localparam logic [1:0]  CELL_EMPTY = 2'b00;
    localparam logic [1:0]  CELL_SHIP  = 2'b01;
    localparam logic [3:0]  LAST_IDX   = 4'd11;
    localparam logic [7:0]  LAST_ADDR  = 8'hBB;
    localparam logic [11:0] X_OFS      = 12'(X_POS);
    localparam logic [11:0] Y_OFS      = 12'(Y_POS);
    localparam logic [7:0]  MAX_CNT    = 8'(MAX_SHIPS);

    logic [6:0] cell_x_s;
    logic [6:0] cell_y_s;
    logic       in_grid_s;
    logic       click_s;
    logic [7:0] next_clr_addr_s;

    state_t     state_r;
    logic [7:0] addr_r;
    logic [1:0] wr_data_r;
    logic       we_r;
    logic       busy_r;
    logic [7:0] count_r;
    logic       left_prev_r;

    // Cell coordinates from the wrapped mouse offset, plus click edge detect.
    // Negative offsets wrap to huge cell numbers and fail the range test.
    always_comb begin
        cell_x_s  = 7'((bus.mouse_xpos - X_OFS) >> 5);
        cell_y_s  = 7'((bus.mouse_ypos - Y_OFS) >> 5);
        in_grid_s = (cell_x_s < 7'd12) && (cell_y_s < 7'd12);
        click_s   = bus.mouse_left & ~left_prev_r;
    end

    // Clear scan order: row fastest, wrapping from row 11 to the next column.
    always_comb begin
        next_clr_addr_s = addr_r;
        if (addr_r[3:0] == LAST_IDX) begin
            next_clr_addr_s = {addr_r[7:4] + 4'd1, 4'd0};
        end else begin
            next_clr_addr_s = {addr_r[7:4], addr_r[3:0] + 4'd1};
        end
    end

    // Main controller: click RMW and clear scan, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= 8'h00;
            wr_data_r   <= 2'b00;
            we_r        <= 1'b0;
            busy_r      <= 1'b0;
            count_r     <= 8'd0;
            left_prev_r <= 1'b0;
        end else begin
            left_prev_r <= bus.mouse_left;
            case (state_r)
                IDLE: begin
                    we_r <= 1'b0;
                    if (bus.clear) begin
                        state_r   <= CLR;
                        addr_r    <= 8'h00;
                        wr_data_r <= CELL_EMPTY;
                        we_r      <= 1'b1;
                        busy_r    <= 1'b1;
                        count_r   <= 8'd0;
                    end else if (click_s && in_grid_s) begin
                        state_r <= RD;
                        addr_r  <= {cell_x_s[3:0], cell_y_s[3:0]};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RD: begin
                    state_r <= CHK;
                end
                CHK: begin
                    case (bus.grid_rd_data)
                        CELL_EMPTY: begin
                            if (count_r < MAX_CNT) begin
                                state_r   <= WR;
                                wr_data_r <= CELL_SHIP;
                                we_r      <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end
                        CELL_SHIP: begin
                            state_r   <= WR;
                            wr_data_r <= CELL_EMPTY;
                            we_r      <= 1'b1;
                        end
                        default: begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    endcase
                end
                WR: begin
                    state_r <= IDLE;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    // Guards keep the count inside 0..MAX_SHIPS even if RAM
                    // contents survived a reset.
                    if (wr_data_r == CELL_SHIP) begin
                        if (count_r < MAX_CNT) begin
                            count_r <= count_r + 8'd1;
                        end else begin
                            count_r <= count_r;
                        end
                    end else begin
                        if (count_r != 8'd0) begin
                            count_r <= count_r - 8'd1;
                        end else begin
                            count_r <= count_r;
                        end
                    end
                end
                CLR: begin
                    if (addr_r == LAST_ADDR) begin
                        state_r <= IDLE;
                        we_r    <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        addr_r <= next_clr_addr_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grid_addr    = addr_r;
    assign bus.grid_wr_data = wr_data_r;
    assign bus.grid_we      = we_r;
    assign bus.busy         = busy_r;
    assign bus.ship_count   = count_r;

endmodule

// File: tb/tb_grid_editor.sv
// Directed bench for grid_editor: two instances (MAX_SHIPS 20 and 2) share
// the mouse/clear stimulus, each with its own behavioural grid RAM.
`timescale 1ns/1ps
module tb_grid_editor;
    localparam int XP = 64;
    localparam int YP = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grid_editor_if bus1();
    grid_editor_if bus2();

    grid_editor #(.X_POS(XP), .Y_POS(YP), .MAX_SHIPS(20)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    grid_editor #(.X_POS(XP), .Y_POS(YP), .MAX_SHIPS(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus2.mouse_xpos = bus1.mouse_xpos;
    assign bus2.mouse_ypos = bus1.mouse_ypos;
    assign bus2.mouse_left = bus1.mouse_left;
    assign bus2.clear      = bus1.clear;

    logic [1:0] ram1 [256];
    logic [1:0] ram2 [256];
    logic       ram_zero = 1'b1;
    logic       pre_req = 1'b0;
    logic [7:0] pre_addr = 8'h00;
    logic [1:0] pre_val = 2'b00;

    // Grid RAMs: synchronous write, one-cycle registered read
    always @(posedge clk) begin
        if (ram_zero) begin
            for (int a = 0; a < 256; a++) begin
                ram1[a] <= 2'b00;
                ram2[a] <= 2'b00;
            end
        end else if (pre_req) begin
            ram1[pre_addr] <= pre_val;
            ram2[pre_addr] <= pre_val;
        end else begin
            if (bus1.grid_we) ram1[bus1.grid_addr] <= bus1.grid_wr_data;
            if (bus2.grid_we) ram2[bus2.grid_addr] <= bus2.grid_wr_data;
        end
        bus1.grid_rd_data <= ram1[bus1.grid_addr];
        bus2.grid_rd_data <= ram2[bus2.grid_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         dx;
        int         dy;
        logic       pre_en;
        logic [1:0] pre;
        int         we1;
        logic [7:0] addr;
        logic [1:0] data;
        int         busy1;
        int         cnt1;
        int         we2;
        int         busy2;
        int         cnt2;
    } vec_t;

    vec_t vecs [12];

    task automatic do_click(input int dx, input int dy,
                            output int nwe1, output int wcyc1, output int nbusy1,
                            output int nwe2, output int nbusy2,
                            output logic [7:0] waddr, output logic [1:0] wdata);
        nwe1 = 0; wcyc1 = 0; nbusy1 = 0; nwe2 = 0; nbusy2 = 0;
        waddr = 8'h00; wdata = 2'b00;
        @(negedge clk);
        bus1.mouse_xpos = 12'(XP + dx);
        bus1.mouse_ypos = 12'(YP + dy);
        bus1.mouse_left = 1'b0;
        @(negedge clk);
        bus1.mouse_left = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus1.busy) nbusy1++;
            if (bus2.busy) nbusy2++;
            if (bus2.grid_we) nwe2++;
            if (bus1.grid_we) begin
                nwe1++;
                wcyc1 = k;
                waddr = bus1.grid_addr;
                wdata = bus1.grid_wr_data;
            end
        end
        bus1.mouse_left = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_clear(input bit with_click, input string tag);
        int nwe, first, last, nbusy, ord_err, dat_err, cnt_k1, nonzero;
        logic [7:0] ea;
        nwe = 0; first = 0; last = 0; nbusy = 0; ord_err = 0; dat_err = 0; cnt_k1 = -1;
        @(negedge clk);
        bus1.mouse_xpos = 12'(XP + 40);
        bus1.mouse_ypos = 12'(YP + 70);
        bus1.mouse_left = 1'b0;
        @(negedge clk);
        bus1.clear      = 1'b1;
        bus1.mouse_left = with_click;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            bus1.clear = 1'b0;
            if (k == 1) cnt_k1 = int'(bus1.ship_count);
            if (bus1.busy) nbusy++;
            if (bus1.grid_we) begin
                ea[7:4] = 4'(nwe / 12);
                ea[3:0] = 4'(nwe % 12);
                if (bus1.grid_addr !== ea) ord_err++;
                if (bus1.grid_wr_data !== 2'b00) dat_err++;
                if (nwe == 0) first = k;
                last = k;
                nwe++;
            end
        end
        bus1.mouse_left = 1'b0;
        @(negedge clk);
        nonzero = 0;
        for (int a = 0; a < 256; a++) if (ram1[a] !== 2'b00) nonzero++;
        check({tag, "_writes"}, nwe, 144);
        check({tag, "_first"}, first, 1);
        check({tag, "_last"}, last, 144);
        check({tag, "_busy"}, nbusy, 144);
        check({tag, "_order"}, ord_err, 0);
        check({tag, "_data"}, dat_err, 0);
        check({tag, "_cnt_entry"}, cnt_k1, 0);
        check({tag, "_cnt2"}, bus2.ship_count, 8'd0);
        check({tag, "_ram_nonzero"}, nonzero, 0);
    endtask

    initial begin
        int nwe1, wcyc1, nbusy1, nwe2, nbusy2, n, found;
        logic [7:0] waddr;
        logic [1:0] wdata;

        //           dx   dy  pre  val   we  addr   data  b1 c1 we2 b2 c2
        vecs[0]  = '{40,  70, 1'b0, 2'b00, 1, 8'h12, 2'b01, 3, 1, 1, 3, 1};
        vecs[1]  = '{40,  70, 1'b0, 2'b00, 1, 8'h12, 2'b00, 3, 0, 1, 3, 0};
        vecs[2]  = '{-1,   0, 1'b0, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 0, 0};
        vecs[3]  = '{384,  0, 1'b0, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 0, 0};
        vecs[4]  = '{0,  384, 1'b0, 2'b00, 0, 8'h00, 2'b00, 0, 0, 0, 0, 0};
        vecs[5]  = '{1,    1, 1'b0, 2'b00, 1, 8'h00, 2'b01, 3, 1, 1, 3, 1};
        vecs[6]  = '{383, 383, 1'b0, 2'b00, 1, 8'hBB, 2'b01, 3, 2, 1, 3, 2};
        vecs[7]  = '{138, 163, 1'b1, 2'b10, 0, 8'h45, 2'b00, 2, 2, 0, 2, 2};
        vecs[8]  = '{170, 163, 1'b1, 2'b11, 0, 8'h55, 2'b00, 2, 2, 0, 2, 2};
        vecs[9]  = '{100, 200, 1'b0, 2'b00, 1, 8'h36, 2'b01, 3, 3, 0, 2, 2};
        vecs[10] = '{200,  10, 1'b0, 2'b00, 1, 8'h60, 2'b01, 3, 4, 0, 2, 2};
        vecs[11] = '{300,  40, 1'b0, 2'b00, 1, 8'h91, 2'b01, 3, 5, 0, 2, 2};

        bus1.mouse_xpos = 12'd0;
        bus1.mouse_ypos = 12'd0;
        bus1.mouse_left = 1'b0;
        bus1.clear      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", bus1.grid_addr, 8'h00);
        check("rst_wdata", bus1.grid_wr_data, 2'b00);
        check("rst_we", bus1.grid_we, 1'b0);
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_cnt", bus1.ship_count, 8'd0);
        check("rst_cnt2", bus2.ship_count, 8'd0);
        ram_zero = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pre_en) begin
                pre_addr = vecs[i].addr;
                pre_val  = vecs[i].pre;
                pre_req  = 1'b1;
                @(negedge clk);
                pre_req  = 1'b0;
            end
            do_click(vecs[i].dx, vecs[i].dy, nwe1, wcyc1, nbusy1, nwe2, nbusy2, waddr, wdata);
            check($sformatf("v%0d_we1", i), nwe1, vecs[i].we1);
            check($sformatf("v%0d_busy1", i), nbusy1, vecs[i].busy1);
            check($sformatf("v%0d_cnt1", i), bus1.ship_count, vecs[i].cnt1);
            check($sformatf("v%0d_we2", i), nwe2, vecs[i].we2);
            check($sformatf("v%0d_busy2", i), nbusy2, vecs[i].busy2);
            check($sformatf("v%0d_cnt2", i), bus2.ship_count, vecs[i].cnt2);
            if (vecs[i].we1 == 1) begin
                check($sformatf("v%0d_addr", i), waddr, vecs[i].addr);
                check($sformatf("v%0d_data", i), wdata, vecs[i].data);
                check($sformatf("v%0d_wcyc", i), wcyc1, 3);
            end
        end

        // Full clear starting from five ships, then clear racing a click
        check("pre_clear_cnt", bus1.ship_count, 8'd5);
        run_clear(1'b0, "clr");
        run_clear(1'b1, "clrclick");

        // Button held for 100 cycles gives exactly one RMW
        @(negedge clk);
        bus1.mouse_xpos = 12'(XP + 40);
        bus1.mouse_ypos = 12'(YP + 70);
        bus1.mouse_left = 1'b0;
        @(negedge clk);
        bus1.mouse_left = 1'b1;
        n = 0;
        waddr = 8'h00;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus1.grid_we) begin
                n++;
                waddr = bus1.grid_addr;
            end
        end
        bus1.mouse_left = 1'b0;
        repeat (3) @(negedge clk);
        check("held_writes", n, 1);
        check("held_addr", waddr, 8'h12);
        check("held_cnt1", bus1.ship_count, 8'd1);
        check("held_cnt2", bus2.ship_count, 8'd1);

        // Reset lands on the 50th clear write
        @(negedge clk);
        bus1.clear = 1'b1;
        n = 0;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            bus1.clear = 1'b0;
            if (bus1.grid_we) n++;
            if (n == 50) begin
                rst = 1'b1;
                found = 1;
            end
        end
        check("rstclr_reached50", found, 1);
        @(negedge clk);
        check("rstclr_we", bus1.grid_we, 1'b0);
        check("rstclr_busy", bus1.busy, 1'b0);
        check("rstclr_cnt", bus1.ship_count, 8'd0);
        check("rstclr_addr", bus1.grid_addr, 8'h00);
        check("rstclr_we2", bus2.grid_we, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        do_click(40, 70, nwe1, wcyc1, nbusy1, nwe2, nbusy2, waddr, wdata);
        check("post_rst_we", nwe1, 1);
        check("post_rst_addr", waddr, 8'h12);
        check("post_rst_data", wdata, 2'b01);
        check("post_rst_wcyc", wcyc1, 3);
        check("post_rst_busy", nbusy1, 3);
        check("post_rst_cnt1", bus1.ship_count, 8'd1);
        check("post_rst_cnt2", bus2.ship_count, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
